// File: rtl/hazard_pkg.sv
// Shared defaults and stall-cause bit positions for the scoreboard hazard unit.
package hazard_pkg;

    localparam int WB_LAT_DEF   = 2;
    localparam int FLAG_LAT_DEF = 1;

    localparam int CAUSE_LU   = 0;
    localparam int CAUSE_FLAG = 1;
    localparam int CAUSE_BR   = 2;
    localparam int CAUSE_W    = 3;

endpackage

// File: rtl/reg_pend_ctr.sv
// Pending-result counter for one tracked resource: load on issue, count down to zero,
// freeze while memory is busy. The ld bit marks results still owed by a load.
module reg_pend_ctr #(
    parameter int               CNT_W    = 3,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             load,
    input  logic             ld_in,
    output logic [CNT_W-1:0] cnt,
    output logic             ld
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_q, ld_d;

    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        if (!freeze) begin
            // a fresh issue wins over the countdown in the same cycle
            if (load) begin
                cnt_d = LOAD_VAL;
                ld_d  = ld_in;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    ld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ld_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

    assign cnt = cnt_q;
    assign ld  = ld_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard detection from a per-register scoreboard plus a flag counter;
// produces stall/flush controls, a live stall-cause vector and a saturating stall counter.
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int WB_LAT   = WB_LAT_DEF,
    parameter int FLAG_LAT = FLAG_LAT_DEF,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              id_sets_flags,
    input  logic              id_branch,
    input  logic              id_br,
    input  logic              mem_busy,
    input  logic              branch_mispredicted,
    input  logic              branch_taken,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_flush,
    output logic              if_flush,
    output logic [CAUSE_W-1:0] stall_cause,
    output logic [PERF_W-1:0] stall_count
);

    localparam int               NUM_REGS   = 2**REG_AW;
    localparam logic [CNT_W-1:0] WB_LAT_C   = CNT_W'(WB_LAT);
    localparam logic [CNT_W-1:0] FLAG_LAT_C = CNT_W'(FLAG_LAT);

    logic [CNT_W-1:0]    pend [NUM_REGS];
    logic [NUM_REGS-1:0] ld;
    logic [CNT_W-1:0]    flag_pend;
    logic                unused_flag_ld;
    logic                hazard;
    logic                issue;

    // register 0 is hard-wired idle so it can never produce a match
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign pend[gi] = '0;
                assign ld[gi]   = 1'b0;
            end else begin : g_ctr
                reg_pend_ctr #(
                    .CNT_W    (CNT_W),
                    .LOAD_VAL (WB_LAT_C)
                ) u_ctr (
                    .clk    (clk),
                    .rst_n  (rst_n),
                    .freeze (mem_busy),
                    .load   (issue && id_regwrite && (id_rd == REG_AW'(gi))),
                    .ld_in  (id_is_load),
                    .cnt    (pend[gi]),
                    .ld     (ld[gi])
                );
            end
        end
    endgenerate

    reg_pend_ctr #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (FLAG_LAT_C)
    ) u_flag_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (mem_busy),
        .load   (issue && id_sets_flags),
        .ld_in  (1'b0),
        .cnt    (flag_pend),
        .ld     (unused_flag_ld)
    );

    always_comb begin
        stall_cause = '0;
        // store data can be forwarded MEM-to-MEM, so a store's rt never waits on a load
        stall_cause[CAUSE_LU] = (id_rs_used && ld[id_rs] && (pend[id_rs] == WB_LAT_C)) ||
                                (id_rt_used && ld[id_rt] && (pend[id_rt] == WB_LAT_C) && !id_is_store);
        stall_cause[CAUSE_FLAG] = (id_branch || id_br) && (flag_pend != '0);
        stall_cause[CAUSE_BR]   = id_br && (pend[id_rs] != '0);
    end

    assign hazard      = |stall_cause;
    assign if_flush    = branch_mispredicted && branch_taken;
    assign issue       = id_valid && !hazard && !mem_busy && !if_flush;
    assign pc_stall    = hazard || mem_busy;
    assign if_id_stall = hazard || mem_busy;
    assign id_flush    = hazard && !mem_busy;

    logic [PERF_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard && !mem_busy && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit; a second narrow-counter instance shares the inputs
// so stall_count saturation is reachable in a short run.
module tb_scoreboard_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used, id_regwrite, id_is_load, id_is_store;
    logic       id_sets_flags, id_branch, id_br, mem_busy;
    logic       branch_mispredicted, branch_taken;

    logic        pc_stall, if_id_stall, id_flush, if_flush;
    logic [2:0]  stall_cause;
    logic [15:0] stall_count;

    logic        s_pc_stall, s_if_id_stall, s_id_flush, s_if_flush;
    logic [2:0]  s_stall_cause;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_is_store(id_is_store), .id_sets_flags(id_sets_flags),
        .id_branch(id_branch), .id_br(id_br), .mem_busy(mem_busy),
        .branch_mispredicted(branch_mispredicted), .branch_taken(branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_flush(id_flush),
        .if_flush(if_flush), .stall_cause(stall_cause), .stall_count(stall_count)
    );

    scoreboard_hazard_unit #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_is_store(id_is_store), .id_sets_flags(id_sets_flags),
        .id_branch(id_branch), .id_br(id_br), .mem_busy(mem_busy),
        .branch_mispredicted(branch_mispredicted), .branch_taken(branch_taken),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .id_flush(s_id_flush),
        .if_flush(s_if_flush), .stall_cause(s_stall_cause), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_used = 0; id_rt_used = 0; id_regwrite = 0; id_is_load = 0; id_is_store = 0;
        id_sets_flags = 0; id_branch = 0; id_br = 0; mem_busy = 0;
        branch_mispredicted = 0; branch_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clr();
        repeat (4) tick();
    endtask

    task automatic set_alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        clr();
        id_valid = 1; id_regwrite = 1; id_rd = rd;
        id_rs = rs; id_rs_used = 1; id_rt = rt; id_rt_used = 1;
    endtask

    task automatic set_lw(input logic [3:0] rd);
        clr();
        id_valid = 1; id_regwrite = 1; id_is_load = 1; id_rd = rd;
        id_rs = 4'd1; id_rs_used = 1;
    endtask

    task automatic set_br(input logic [3:0] rs);
        clr();
        id_valid = 1; id_br = 1; id_rs = rs; id_rs_used = 1;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #2;
        chk("rst_cause", 32'(stall_cause), 0);
        chk("rst_pc_stall", 32'(pc_stall), 0);
        chk("rst_count", 32'(stall_count), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // LW r3 then ADD r4,r3,r5
        set_lw(4'd3);
        #2 chk("t1_lw_cause", 32'(stall_cause), 0);
        tick();
        set_alu(4'd4, 4'd3, 4'd5);
        #2 chk("t1_add_cause", 32'(stall_cause), 1);
        chk("t1_add_flush", 32'(id_flush), 1);
        chk("t1_add_pcstall", 32'(pc_stall), 1);
        chk("t1_add_ifidstall", 32'(if_id_stall), 1);
        tick();
        #2 chk("t1_add_issue_cause", 32'(stall_cause), 0);
        chk("t1_add_issue_flush", 32'(id_flush), 0);
        chk("t1_count", 32'(stall_count), 1);
        tick();
        drain();

        // LW r3 then SW with r3 as store data, then as address
        set_lw(4'd3);
        tick();
        clr(); id_valid = 1; id_is_store = 1; id_rs = 4'd1; id_rs_used = 1; id_rt = 4'd3; id_rt_used = 1;
        #2 chk("t2_sw_data_cause", 32'(stall_cause), 0);
        tick();
        drain();
        set_lw(4'd3);
        tick();
        clr(); id_valid = 1; id_is_store = 1; id_rs = 4'd3; id_rs_used = 1; id_rt = 4'd6; id_rt_used = 1;
        #2 chk("t2_sw_addr_cause", 32'(stall_cause), 1);
        tick();
        #2 chk("t2_sw_addr_clear", 32'(stall_cause), 0);
        chk("t2_count", 32'(stall_count), 2);
        tick();
        drain();

        // ADD r2 then BR r2: two br_src stall cycles
        set_alu(4'd2, 4'd1, 4'd1);
        tick();
        set_br(4'd2);
        #2 chk("t3_br_c1", 32'(stall_cause), 4);
        tick();
        #2 chk("t3_br_c2", 32'(stall_cause), 4);
        tick();
        #2 chk("t3_br_c3", 32'(stall_cause), 0);
        chk("t3_count", 32'(stall_count), 4);
        tick();
        drain();
        set_alu(4'd0, 4'd1, 4'd1);
        tick();
        set_br(4'd0);
        #2 chk("t3_br_r0_cause", 32'(stall_cause), 0);
        chk("t3_br_r0_pcstall", 32'(pc_stall), 0);
        tick();
        drain();

        // SUB sets flags then B, with mem_busy held 3 cycles during the stall
        set_alu(4'd7, 4'd1, 4'd1); id_sets_flags = 1;
        tick();
        clr(); id_valid = 1; id_branch = 1; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("t4_busy_cause", 32'(stall_cause), 2);
            chk("t4_busy_flush", 32'(id_flush), 0);
            chk("t4_busy_pcstall", 32'(pc_stall), 1);
            chk("t4_busy_count", 32'(stall_count), 4);
            tick();
        end
        mem_busy = 0;
        #2 chk("t4_flag_cause", 32'(stall_cause), 2);
        chk("t4_flag_flush", 32'(id_flush), 1);
        tick();
        #2 chk("t4_flag_clear", 32'(stall_cause), 0);
        chk("t4_count", 32'(stall_count), 5);
        tick();
        drain();

        // an instruction held by mem_busy never issues
        set_lw(4'd8); mem_busy = 1;
        #2 chk("t4_lw_busy_pcstall", 32'(pc_stall), 1);
        chk("t4_lw_busy_flush", 32'(id_flush), 0);
        tick();
        set_alu(4'd9, 4'd8, 4'd8);
        #2 chk("t4_after_busy_cause", 32'(stall_cause), 0);
        tick();
        drain();

        // misprediction squash
        set_lw(4'd10); branch_mispredicted = 1; branch_taken = 1;
        #2 chk("t5_if_flush_taken", 32'(if_flush), 1);
        tick();
        set_alu(4'd11, 4'd10, 4'd10);
        #2 chk("t5_squashed_no_stall", 32'(stall_cause), 0);
        tick();
        clr(); branch_mispredicted = 1; branch_taken = 0;
        #2 chk("t5_if_flush_nottaken", 32'(if_flush), 0);
        tick();
        drain();

        // reset in the middle of a load-use stall
        set_lw(4'd5);
        tick();
        set_alu(4'd6, 4'd5, 4'd1);
        #2 chk("t6_pre_rst_cause", 32'(stall_cause), 1);
        rst_n = 0;
        #1 chk("t6_rst_cause", 32'(stall_cause), 0);
        chk("t6_rst_flush", 32'(id_flush), 0);
        chk("t6_rst_count", 32'(stall_count), 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        #2 chk("t6_post_rst_cause", 32'(stall_cause), 0);
        tick();
        drain();

        // saturation: 11 rounds of ADD r2 / BR r2 give 22 stall cycles
        for (int r = 0; r < 11; r++) begin
            set_alu(4'd2, 4'd1, 4'd1);
            tick();
            set_br(4'd2);
            repeat (3) tick();
            if (r == 6) begin
                clr();
                #2 chk("t6_sat_mid", 32'(s_stall_count), 14);
            end
        end
        clr();
        #2 chk("t6_sat_full", 32'(s_stall_count), 15);
        chk("t6_wide_count", 32'(stall_count), 22);
        set_br(4'd2);
        #2 chk("t6_sat_idle_cause", 32'(s_stall_cause), 0);
        tick();
        chk("t6_sat_hold", 32'(s_stall_count), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
